// File: rtl/ysyx_23060201_ifu_pkg.sv
// Shared definitions for the multi-cycle instruction fetch unit:
// FSM state encoding, reset PC and AXI read response code.
package ysyx_23060201_ifu_pkg;

   typedef enum logic [2:0] {
      S_AR   = 3'd0,
      S_R    = 3'd1,
      S_OUT  = 3'd2,
      S_WAIT = 3'd3,
      S_ERR  = 3'd4
   } ifu_state_e;

   localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
   localparam logic [1:0]  RESP_OKAY    = 2'b00;

endpackage

// File: rtl/ysyx_23060201_ifu.sv
// Instruction fetch unit: owns the PC, issues one AR/R read per instruction,
// hands {pc, inst} to IDU and waits for the EXU commit before fetching again.
module ysyx_23060201_ifu
   import ysyx_23060201_ifu_pkg::*;
#(
   parameter int unsigned        ADDR_W   = 32,
   parameter int unsigned        DATA_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(IFU_RESET_PC)
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] araddr,
   output logic              arvalid,
   input  logic              arready,
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        rresp,
   input  logic              rvalid,
   output logic              rready,
   output logic [DATA_W-1:0] inst,
   output logic [ADDR_W-1:0] pc,
   output logic              inst_valid,
   input  logic              inst_ready,
   input  logic              commit_valid,
   input  logic [ADDR_W-1:0] dnpc,
   output logic              commit_ready,
   output logic              fetch_err
);

   ifu_state_e        r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [DATA_W-1:0] r_inst;
   logic              r_err;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_AR;
         r_pc    <= RESET_PC;
         r_inst  <= '0;
         r_err   <= 1'b0;
      end else begin
         unique case (r_state)
            S_AR: begin
               if (arready) r_state <= S_R;
            end
            S_R: begin
               if (rvalid) begin
                  if (rresp == RESP_OKAY) begin
                     r_inst  <= rdata;
                     r_state <= S_OUT;
                  end else begin
                     r_err   <= 1'b1;
                     r_state <= S_ERR;
                  end
               end
            end
            S_OUT: begin
               if (inst_ready) r_state <= S_WAIT;
            end
            S_WAIT: begin
               // pc takes dnpc even when misaligned so the faulting target stays visible
               if (commit_valid) begin
                  r_pc <= dnpc;
                  if (dnpc[1:0] == 2'b00) begin
                     r_state <= S_AR;
                  end else begin
                     r_err   <= 1'b1;
                     r_state <= S_ERR;
                  end
               end
            end
            S_ERR: begin
               r_state <= S_ERR;
            end
            default: begin
               r_state <= S_ERR;
            end
         endcase
      end
   end

   assign araddr       = r_pc;
   assign pc           = r_pc;
   assign inst         = r_inst;
   assign fetch_err    = r_err;
   assign arvalid      = (r_state == S_AR);
   assign rready       = (r_state == S_R);
   assign inst_valid   = (r_state == S_OUT);
   assign commit_ready = (r_state == S_WAIT);

endmodule

// File: tb/tb_ysyx_23060201_ifu.sv
// Scoreboard bench for the fetch unit: expected AR addresses and IDU words are
// queued as stimulus is issued and popped by a negedge monitor on handshakes.
module tb_ysyx_23060201_ifu;

   localparam logic [31:0] RPC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready = 1'b0;
   logic [31:0] rdata = '0;
   logic [1:0]  rresp = '0;
   logic        rvalid = 1'b0;
   logic        rready;
   logic [31:0] inst;
   logic [31:0] pc;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic        commit_valid = 1'b0;
   logic [31:0] dnpc = '0;
   logic        commit_ready;
   logic        fetch_err;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] q_ar[$];
   logic [63:0] q_out[$];

   ysyx_23060201_ifu #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .RESET_PC (RPC)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .araddr       (araddr),
      .arvalid      (arvalid),
      .arready      (arready),
      .rdata        (rdata),
      .rresp        (rresp),
      .rvalid       (rvalid),
      .rready       (rready),
      .inst         (inst),
      .pc           (pc),
      .inst_valid   (inst_valid),
      .inst_ready   (inst_ready),
      .commit_valid (commit_valid),
      .dnpc         (dnpc),
      .commit_ready (commit_ready),
      .fetch_err    (fetch_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every AR and IDU handshake must match the head of its queue
   always @(negedge clk) begin
      if (rst && arvalid && arready) begin
         if (q_ar.size() == 0) chk("ar_unexpected", 64'(araddr), 64'hFFFF_FFFF_FFFF_FFFF);
         else chk("ar_addr", 64'(araddr), 64'(q_ar.pop_front()));
      end
      if (rst && inst_valid && inst_ready) begin
         if (q_out.size() == 0) chk("idu_unexpected", {pc, inst}, 64'hFFFF_FFFF_FFFF_FFFF);
         else chk("idu_pc_inst", {pc, inst}, q_out.pop_front());
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; arready = 1'b0; rvalid = 1'b0;
      commit_valid = 1'b0; inst_ready = 1'b0;
      step();
      chk("rst_arvalid", 64'(arvalid), 64'd1);
      chk("rst_pc", 64'(pc), 64'(RPC));
      chk("rst_inst", 64'(inst), 64'd0);
      chk("rst_err", 64'(fetch_err), 64'd0);
      chk("rst_hs", {61'd0, rready, inst_valid, commit_ready}, 64'd0);
      rst = 1'b1;
   endtask

   task automatic fetch(input logic [31:0] addr, input logic [31:0] data,
                        input logic [1:0] resp, input int ar_delay);
      logic [31:0] prev_inst;
      prev_inst = inst;
      q_ar.push_back(addr);
      if (resp == 2'b00) q_out.push_back({addr, data});
      chk("ar_valid_entry", 64'(arvalid), 64'd1);
      for (int i = 0; i < ar_delay; i++) begin
         chk("ar_hold_addr", {31'd0, arvalid, araddr}, {31'd0, 1'b1, addr});
         step();
      end
      arready = 1'b1;
      step();
      arready = 1'b0;
      chk("r_ready", {62'd0, rready, arvalid}, 64'd2);
      rvalid = 1'b1; rdata = data; rresp = resp;
      step();
      rvalid = 1'b0; rresp = 2'b00;
      if (resp == 2'b00) begin
         chk("out_valid", 64'(inst_valid), 64'd1);
      end else begin
         chk("err_flag", 64'(fetch_err), 64'd1);
         chk("err_no_out", 64'(inst_valid), 64'd0);
         chk("err_inst_kept", 64'(inst), 64'(prev_inst));
      end
   endtask

   // Holds IDU off for n cycles while driving stray R/commit traffic that must be ignored
   task automatic consume(input int n, input logic [31:0] exp_pc, input logic [31:0] exp_inst);
      for (int i = 0; i < n; i++) begin
         commit_valid = 1'b1; dnpc = 32'h1234_5678;
         rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
         chk("hold_valid", 64'(inst_valid), 64'd1);
         chk("hold_pc_inst", {pc, inst}, {exp_pc, exp_inst});
         chk("hold_no_commit", 64'(commit_ready), 64'd0);
         step();
      end
      commit_valid = 1'b0; rvalid = 1'b0;
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
   endtask

   task automatic commit(input logic [31:0] d);
      chk("commit_ready", {62'd0, commit_ready, inst_valid}, 64'd2);
      commit_valid = 1'b1; dnpc = d;
      step();
      commit_valid = 1'b0;
      if (d[1:0] == 2'b00) begin
         chk("next_ar", {31'd0, arvalid, araddr}, {31'd0, 1'b1, d});
      end else begin
         chk("misalign_err", 64'(fetch_err), 64'd1);
         chk("misalign_pc", 64'(pc), 64'(d));
      end
   endtask

   task automatic check_halted(input int n);
      for (int i = 0; i < n; i++) begin
         arready = 1'b1; rvalid = 1'b1; commit_valid = 1'b1; inst_ready = 1'b1;
         step();
         chk("halt_outputs", {59'd0, fetch_err, arvalid, rready, inst_valid, commit_ready}, 64'h10);
      end
      arready = 1'b0; rvalid = 1'b0; commit_valid = 1'b0; inst_ready = 1'b0;
   endtask

   initial begin
      do_reset();
      chk("boot_ar", {31'd0, arvalid, araddr}, {31'd0, 1'b1, RPC});

      fetch(RPC, 32'h0000_0413, 2'b00, 0);
      consume(5, RPC, 32'h0000_0413);
      commit(32'h8000_0004);
      fetch(32'h8000_0004, 32'h0010_0093, 2'b00, 3);
      consume(0, 32'h8000_0004, 32'h0010_0093);
      commit(32'h8000_0004);
      fetch(32'h8000_0004, 32'h0020_0113, 2'b00, 0);
      consume(1, 32'h8000_0004, 32'h0020_0113);
      commit(32'h8000_0008);
      fetch(32'h8000_0008, 32'hCAFE_F00D, 2'b10, 0);
      check_halted(4);

      do_reset();
      fetch(RPC, 32'h0000_0013, 2'b00, 0);
      consume(0, RPC, 32'h0000_0013);
      commit(32'h8000_0006);
      check_halted(3);

      do_reset();
      q_ar.push_back(RPC);
      arready = 1'b1;
      step();
      arready = 1'b0;
      chk("sr_rready", 64'(rready), 64'd1);
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk("mid_rst", {30'd0, fetch_err, rready, arvalid, araddr}, {30'd0, 1'b0, 1'b0, 1'b1, RPC});
      fetch(RPC, 32'h0000_0093, 2'b00, 1);
      consume(0, RPC, 32'h0000_0093);

      chk("q_ar_empty", 64'(q_ar.size()), 64'd0);
      chk("q_out_empty", 64'(q_out.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
